// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: sizing constants and FSM state codes.
package change_dispenser_pkg;

    localparam int unsigned K_NUM_COINS      = 3;
    localparam int unsigned K_TOTAL_BITS     = 31;
    localparam int unsigned K_COIN_BITS      = 32;
    localparam int unsigned K_RETURN_TIMEOUT = 100;

    typedef enum logic [1:0] {
        DISP_IDLE = 2'd0,
        DISP_RUN  = 2'd1,
        DISP_DONE = 2'd2
    } disp_state_e;

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Greedy coin picker (combinational).
//   remainder   : amount still to be returned
//   coin_value  : NUM_COINS x 32-bit denominations, strictly ascending by index
//   sel_c       : one-hot index of the largest denomination <= remainder
//   none_fits_c : no denomination fits (remainder below the smallest coin)
module change_dispenser_coin_selector
    import change_dispenser_pkg::*;
#(
    parameter int unsigned NUM_COINS  = K_NUM_COINS,
    parameter int unsigned TOTAL_BITS = K_TOTAL_BITS
) (
    input  logic [TOTAL_BITS-1:0]             remainder,
    input  logic [NUM_COINS*K_COIN_BITS-1:0]  coin_value,
    output logic [NUM_COINS-1:0]              sel_c,
    output logic                              none_fits_c
);

    logic [K_COIN_BITS-1:0] rem_ext;

    assign rem_ext = K_COIN_BITS'(remainder);

    // Ascending scan: the last hit is the highest fitting index.
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            if (coin_value[i*K_COIN_BITS +: K_COIN_BITS] <= rem_ext) begin
                sel_c = '0;
                sel_c[i] = 1'b1;
            end
        end
    end

    assign none_fits_c = (sel_c == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: latches the machine total on a return request and pays it out
// as coins, largest denomination first, one coin per hopper handshake.
// Optional feature macro: RETURN_TIMEOUT_EN (auto-return after an idle timeout).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   i_trigger_return   : return request, honoured in IDLE only
//   i_activity         : user activity, restarts the idle timer (timeout build only)
//   i_hopper_ready     : hopper accepts the presented coin this cycle
//   current_total      : registered machine total, latched on trigger
//   coin_value         : NUM_COINS x 32-bit denominations, ascending
//   o_return_coin      : one-hot coin presented (0 when not valid)
//   o_coin_valid       : coin offered to hopper
//   o_busy             : return in progress (DISPENSE or DONE)
//   o_done             : one-cycle completion pulse
//   o_residual         : undispensable remainder, valid with o_done
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned NUM_COINS  = K_NUM_COINS,
    parameter int unsigned TOTAL_BITS = K_TOTAL_BITS
`ifdef RETURN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = K_RETURN_TIMEOUT
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_trigger_return,
    input  logic                             i_activity,
    input  logic                             i_hopper_ready,
    input  logic [TOTAL_BITS-1:0]            current_total,
    input  logic [NUM_COINS*K_COIN_BITS-1:0] coin_value,
    output logic [NUM_COINS-1:0]             o_return_coin,
    output logic                             o_coin_valid,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [TOTAL_BITS-1:0]            o_residual
);

    disp_state_e             state_q, state_d;
    logic [TOTAL_BITS-1:0]   remainder_q, remainder_d;
    logic [NUM_COINS-1:0]    cur_sel_c, nxt_sel_c;
    logic                    cur_none_fits_c, nxt_none_fits_c;
    logic [K_COIN_BITS-1:0]  cur_value_c;
    logic [K_COIN_BITS-1:0]  rem_ext_c;
    logic                    transfer_c;
    logic                    trigger_c;

    // Coin matching the current remainder (what is on offer right now).
    change_dispenser_coin_selector #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_cur_sel (
        .remainder   (remainder_q),
        .coin_value  (coin_value),
        .sel_c       (cur_sel_c),
        .none_fits_c (cur_none_fits_c)
    );

    // Coin matching the next remainder; feeds the registered outputs.
    change_dispenser_coin_selector #(
        .NUM_COINS  (NUM_COINS),
        .TOTAL_BITS (TOTAL_BITS)
    ) u_nxt_sel (
        .remainder   (remainder_d),
        .coin_value  (coin_value),
        .sel_c       (nxt_sel_c),
        .none_fits_c (nxt_none_fits_c)
    );

    // Value of the offered coin, picked by its one-hot select.
    always_comb begin
        cur_value_c = '0;
        for (int i = 0; i < int'(NUM_COINS); i++) begin
            if (cur_sel_c[i]) begin
                cur_value_c = cur_value_c | coin_value[i*K_COIN_BITS +: K_COIN_BITS];
            end
        end
    end

    assign rem_ext_c  = K_COIN_BITS'(remainder_q);
    assign transfer_c = o_coin_valid & i_hopper_ready;

`ifdef RETURN_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
    logic        timeout_fire_c;

    // Idle timer: counts quiet idle cycles while money is held.
    always_comb begin
        timer_d        = timer_q;
        timeout_fire_c = 1'b0;
        if ((state_q != DISP_IDLE) || i_activity || (current_total == '0)) begin
            timer_d = '0;
        end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
            timer_d        = '0;
            timeout_fire_c = 1'b1;
        end else begin
            timer_d = timer_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // A coincident user trigger merges into the same single return.
    assign trigger_c = i_trigger_return | timeout_fire_c;
`else
    logic unused_activity;

    assign unused_activity = i_activity;
    assign trigger_c       = i_trigger_return;
`endif

    // Remainder update: load on trigger, subtract on each accepted coin, clear after DONE.
    always_comb begin
        remainder_d = remainder_q;
        case (state_q)
            DISP_IDLE: begin
                if (trigger_c) begin
                    remainder_d = current_total;
                end
            end
            DISP_RUN: begin
                if (transfer_c && !cur_none_fits_c) begin
                    remainder_d = TOTAL_BITS'(rem_ext_c - cur_value_c);
                end
            end
            default: begin
                remainder_d = '0;
            end
        endcase
    end

    // Next state: DONE as soon as nothing more fits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DISP_IDLE: begin
                if (trigger_c) begin
                    state_d = nxt_none_fits_c ? DISP_DONE : DISP_RUN;
                end
            end
            DISP_RUN: begin
                // cur_none_fits_c only guards against denominations changed mid-return.
                if (cur_none_fits_c || (transfer_c && nxt_none_fits_c)) begin
                    state_d = DISP_DONE;
                end
            end
            DISP_DONE: begin
                state_d = DISP_IDLE;
            end
            default: begin
                state_d = DISP_IDLE;
            end
        endcase
    end

    // State, remainder and outputs; outputs are registered from next-state values
    // so a coin appears the cycle after the trigger and holds until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= DISP_IDLE;
            remainder_q   <= '0;
            o_return_coin <= '0;
            o_coin_valid  <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_residual    <= '0;
        end else begin
            state_q       <= state_d;
            remainder_q   <= remainder_d;
            o_coin_valid  <= (state_d == DISP_RUN);
            o_return_coin <= (state_d == DISP_RUN) ? nxt_sel_c : '0;
            o_busy        <= (state_d != DISP_IDLE);
            o_done        <= (state_d == DISP_DONE);
            o_residual    <= (state_d == DISP_DONE) ? remainder_d : '0;
        end
    end

endmodule
